// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled UART receiver with error detection and an output FIFO
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               Rst,
  input  logic                               enable,
  input  logic                               Rx,
  output logic [DATA_BITS-1:0]               data_out,
  output logic                               data_valid,
  input  logic                               data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               rx_busy,
  output logic                               parity_error,
  output logic                               framing_error,
  output logic                               break_detect,
  output logic                               overrun
);

  localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int M       = OVERSAMPLE / 2;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_LO      = TW'(M - 1);
  localparam logic [TW-1:0] T_MID     = TW'(M);
  localparam logic [TW-1:0] T_HI      = TW'(M + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [DW-1:0]        div_cnt;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 samp0, samp1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_bad;
  logic                 done;
  logic                 frame_perr, frame_ferr, frame_brk;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  logic tick, start_edge, maj, full, pop, push;

  assign tick       = (div_cnt == DIV_LAST);
  assign start_edge = enable && rx_prev && !rx_s2;
  assign maj        = (samp0 & samp1) | (samp0 & rx_s2) | (samp1 & rx_s2);
  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign data_valid = (fifo_count != '0);
  assign pop        = data_valid && data_ready;
  assign push       = done && !frame_perr && !frame_ferr && (!full || pop);
  assign data_out   = mem[rd_ptr];
  assign rx_busy    = (state != S_IDLE);

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= Rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Oversampling tick divider, realigned to each detected start edge
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      div_cnt <= '0;
    end else if ((state == S_IDLE && start_edge) || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Receive FSM: majority-voted mid-bit sampling and frame assembly
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      samp0      <= 1'b1;
      samp1      <= 1'b1;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_bad   <= 1'b0;
      done       <= 1'b0;
      frame_perr <= 1'b0;
      frame_ferr <= 1'b0;
      frame_brk  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state <= S_IDLE;
      end else if (state == S_IDLE) begin
        if (start_edge) begin
          state    <= S_START;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          par_bit  <= 1'b0;
          stop_bad <= 1'b0;
        end
      end else if (tick) begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        if (tick_cnt == T_LO)  samp0 <= rx_s2;
        if (tick_cnt == T_MID) samp1 <= rx_s2;
        if (tick_cnt == T_HI) begin
          case (state)
            S_START: state <= maj ? S_IDLE : S_DATA;
            S_DATA: begin
              shreg <= {maj, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= HAS_PAR ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
            S_PARITY: begin
              par_bit <= maj;
              state   <= S_STOP;
            end
            S_STOP: begin
              if (!maj) stop_bad <= 1'b1;
              if (stop_cnt == STOP_LAST) begin
                state      <= S_IDLE;
                done       <= 1'b1;
                frame_ferr <= stop_bad || !maj;
                frame_perr <= HAS_PAR && ((^shreg) ^ par_bit ^ PAR_ODD);
                frame_brk  <= (shreg == '0) && !par_bit && (stop_bad || !maj);
              end else begin
                stop_cnt <= 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Output FIFO and one-cycle status pulses on frame completion
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      parity_error  <= done && frame_perr;
      framing_error <= done && frame_ferr;
      break_detect  <= done && frame_brk;
      overrun       <= done && !frame_perr && !frame_ferr && full && !pop;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      fifo_count <= fifo_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard testbench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       Rst;
  logic       enable;
  logic       Rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic [2:0] fifo_count;
  logic       rx_busy;
  logic       parity_error, framing_error, break_detect, overrun;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  int pe_cnt = 0, fe_cnt = 0, bd_cnt = 0, ov_cnt = 0, busy_cnt = 0, long_cnt = 0;
  logic pe_d = 0, fe_d = 0, bd_d = 0, ov_d = 0;

  uart_rx_fifo #(
    .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .Rst(Rst), .enable(enable), .Rx(Rx),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .fifo_count(fifo_count), .rx_busy(rx_busy),
    .parity_error(parity_error), .framing_error(framing_error),
    .break_detect(break_detect), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters and width monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (parity_error)  pe_cnt++;
    if (framing_error) fe_cnt++;
    if (break_detect)  bd_cnt++;
    if (overrun)       ov_cnt++;
    if (rx_busy)       busy_cnt++;
    if ((parity_error && pe_d) || (framing_error && fe_d) ||
        (break_detect && bd_d) || (overrun && ov_d)) long_cnt++;
    pe_d = parity_error; fe_d = framing_error; bd_d = break_detect; ov_d = overrun;
  end

  task automatic bit_time(input logic v);
    Rx = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(p);
    bit_time(s);
    Rx = 1'b1;
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    int budget;
    for (int k = 0; k < n; k++) begin
      budget = 0;
      while (!data_valid && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      vectors++;
      if (!data_valid) begin
        miscompares++;
        $display("FAIL drain_timeout: data_valid=%0b required 1 (entry %0d)", data_valid, k);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL drain_unexpected: data_out=%02h with empty scoreboard", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          miscompares++;
          $display("FAIL drain_data: data_out=%02h required %02h", data_out, e);
        end
      end
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    int b0;
    Rst = 1'b1; Rx = 1'b1; enable = 1'b1; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({data_valid, rx_busy, fifo_count, parity_error, framing_error, break_detect, overrun} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b busy=%0b count=%0d pe=%0b fe=%0b bd=%0b ov=%0b required all 0",
               data_valid, rx_busy, fifo_count, parity_error, framing_error, break_detect, overrun);
    end
    Rst = 1'b0;
    b0 = busy_cnt;
    idle(100);
    vectors++;
    if (busy_cnt - b0 !== 0) begin
      miscompares++;
      $display("FAIL idle_busy: busy cycles=%0d required 0", busy_cnt - b0);
    end
  endtask

  task automatic test_clean_frame;
    int p0, f0, b0, o0;
    p0 = pe_cnt; f0 = fe_cnt; b0 = bd_cnt; o0 = ov_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    exp_q.push_back(8'hA5);
    idle(20);
    vectors++;
    if (fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL clean_count: fifo_count=%0d required 1", fifo_count);
    end
    vectors++;
    if ((pe_cnt - p0) + (fe_cnt - f0) + (bd_cnt - b0) + (ov_cnt - o0) !== 0) begin
      miscompares++;
      $display("FAIL clean_pulses: pe=%0d fe=%0d bd=%0d ov=%0d required 0",
               pe_cnt - p0, fe_cnt - f0, bd_cnt - b0, ov_cnt - o0);
    end
    idle(5);
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL hold_stable: data_out=%02h required a5", data_out);
    end
    drain(1);
    vectors++;
    if (fifo_count !== 3'd0 || data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_pop: fifo_count=%0d valid=%0b required 0/0", fifo_count, data_valid);
    end
  endtask

  task automatic test_errors;
    int p0, f0, b0;
    p0 = pe_cnt; f0 = fe_cnt; b0 = bd_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    vectors++;
    if (pe_cnt - p0 !== 1 || fe_cnt - f0 !== 0 || bd_cnt - b0 !== 0 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL parity_err: pe=%0d fe=%0d bd=%0d count=%0d required 1/0/0/0",
               pe_cnt - p0, fe_cnt - f0, bd_cnt - b0, fifo_count);
    end
    p0 = pe_cnt; f0 = fe_cnt; b0 = bd_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(20);
    vectors++;
    if (pe_cnt - p0 !== 0 || fe_cnt - f0 !== 1 || bd_cnt - b0 !== 0 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL framing_err: pe=%0d fe=%0d bd=%0d count=%0d required 0/1/0/0",
               pe_cnt - p0, fe_cnt - f0, bd_cnt - b0, fifo_count);
    end
    p0 = pe_cnt; f0 = fe_cnt; b0 = bd_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    idle(20);
    vectors++;
    if (pe_cnt - p0 !== 0 || fe_cnt - f0 !== 1 || bd_cnt - b0 !== 1 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL break_det: pe=%0d fe=%0d bd=%0d count=%0d required 0/1/1/0",
               pe_cnt - p0, fe_cnt - f0, bd_cnt - b0, fifo_count);
    end
    vectors++;
    if (long_cnt !== 0) begin
      miscompares++;
      $display("FAIL pulse_width: multi-cycle pulses=%0d required 0", long_cnt);
    end
  endtask

  task automatic test_glitch;
    int b0, e0;
    b0 = busy_cnt; e0 = pe_cnt + fe_cnt + bd_cnt + ov_cnt;
    Rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(16);
    vectors++;
    if (rx_busy !== 1'b0 || busy_cnt - b0 == 0) begin
      miscompares++;
      $display("FAIL glitch_busy: busy=%0b busy cycles=%0d required 0 and >0", rx_busy, busy_cnt - b0);
    end
    idle(20);
    vectors++;
    if (fifo_count !== 3'd0 || (pe_cnt + fe_cnt + bd_cnt + ov_cnt) - e0 !== 0) begin
      miscompares++;
      $display("FAIL glitch_side: count=%0d pulses=%0d required 0/0",
               fifo_count, (pe_cnt + fe_cnt + bd_cnt + ov_cnt) - e0);
    end
  endtask

  task automatic test_back_to_back;
    int o0, model_cnt;
    int exp_ov;
    o0 = ov_cnt; model_cnt = 0; exp_ov = 0;
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] d;
      d = 8'(k);
      send_frame(d, ^d, 1'b1);
      if (model_cnt < 4) begin
        exp_q.push_back(d);
        model_cnt++;
      end else begin
        exp_ov++;
      end
    end
    idle(20);
    vectors++;
    if (fifo_count !== 3'd4) begin
      miscompares++;
      $display("FAIL b2b_count: fifo_count=%0d required 4", fifo_count);
    end
    vectors++;
    if (ov_cnt - o0 !== exp_ov) begin
      miscompares++;
      $display("FAIL b2b_overrun: overrun pulses=%0d required %0d", ov_cnt - o0, exp_ov);
    end
    drain(4);
    vectors++;
    if (fifo_count !== 3'd0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: fifo_count=%0d left=%0d required 0/0", fifo_count, exp_q.size());
    end
  endtask

  task automatic test_abort;
    int e0;
    // Reset during data bit 3
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b1);
    Rx = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (rx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy_pre: busy=%0b required 1", rx_busy);
    end
    Rst = 1'b1;
    #1;
    vectors++;
    if (rx_busy !== 1'b0 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_abort: busy=%0b count=%0d required 0/0", rx_busy, fifo_count);
    end
    @(negedge clk);
    Rx = 1'b1;
    Rst = 1'b0;
    idle(20);
    send_frame(8'h5A, 1'b0, 1'b1);
    exp_q.push_back(8'h5A);
    idle(20);
    drain(1);
    // Enable drop during data bit 3 with one frame held in the FIFO
    send_frame(8'h11, 1'b0, 1'b1);
    exp_q.push_back(8'h11);
    idle(20);
    e0 = pe_cnt + fe_cnt + bd_cnt + ov_cnt;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b0);
    repeat (8) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    Rx = 1'b1;
    @(negedge clk);
    vectors++;
    if (rx_busy !== 1'b0 || fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL enable_abort: busy=%0b count=%0d required 0/1", rx_busy, fifo_count);
    end
    idle(40);
    enable = 1'b1;
    idle(10);
    vectors++;
    if ((pe_cnt + fe_cnt + bd_cnt + ov_cnt) - e0 !== 0 || fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL enable_side: pulses=%0d count=%0d required 0/1",
               (pe_cnt + fe_cnt + bd_cnt + ov_cnt) - e0, fifo_count);
    end
    send_frame(8'h5A, 1'b0, 1'b1);
    exp_q.push_back(8'h5A);
    idle(20);
    drain(2);
  endtask

  initial begin
    Rst = 1'b1; Rx = 1'b1; enable = 1'b1; data_ready = 1'b0;
    test_reset();
    test_clean_frame();
    test_errors();
    test_glitch();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
